// File: rtl/npu_pkg.sv
// Shared types and constants for the int8 fully-connected NPU engine.
package npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD_IN,
        ST_BIAS,
        ST_MAC,
        ST_REQ,
        ST_STORE,
        ST_DONE
    } npu_state_e;

    localparam int RQ_MULT_W  = 32;
    localparam int RQ_PROD_W  = 64;
    localparam int RQ_EXT_W   = 66;  // headroom for the rounding add and zero-point add
    localparam int RQ_SHIFT_W = 6;

    function automatic longint rq_sat_max(input int data_w);
        return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    endfunction

    function automatic longint rq_sat_min(input int data_w);
        return -(64'sd1 <<< (data_w - 1));
    endfunction

    // Byte distance between consecutive memory words.
    function automatic int word_stride(input int lanes, input int data_w);
        return (lanes * data_w) / 8;
    endfunction

endpackage

// File: rtl/npu_fc_engine_requant.sv
// TFLite-style requantizer: 64b product registered, then round/shift, zero point, saturate, ReLU.
module npu_requant
    import npu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vld_p0,
    input  logic signed [ACC_W-1:0]      acc_p0,
    input  logic signed [RQ_MULT_W-1:0]  mult,
    input  logic        [RQ_SHIFT_W-1:0] shift,
    input  logic signed [DATA_W-1:0]     zp_out,
    input  logic                         relu,
    output logic                         vld_p1,
    output logic signed [DATA_W-1:0]     q_p1
);

    localparam logic signed [RQ_EXT_W-1:0] Q_MAX = RQ_EXT_W'(rq_sat_max(DATA_W));
    localparam logic signed [RQ_EXT_W-1:0] Q_MIN = RQ_EXT_W'(rq_sat_min(DATA_W));

    logic signed [RQ_PROD_W-1:0] t_p0;
    logic signed [RQ_PROD_W-1:0] t_p1;
    logic signed [RQ_EXT_W-1:0]  v_p1;
    logic signed [DATA_W-1:0]    s_p1;

    function automatic logic signed [RQ_EXT_W-1:0] round_shift(
        input logic signed [RQ_PROD_W-1:0] t,
        input logic        [RQ_SHIFT_W-1:0] sh
    );
        logic signed [RQ_EXT_W-1:0] e;
        e = RQ_EXT_W'(t);
        if (sh != '0)
            e = e + (RQ_EXT_W'(1) <<< (sh - RQ_SHIFT_W'(1)));
        return e >>> sh;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [RQ_EXT_W-1:0] v);
        if (v > Q_MAX)
            return DATA_W'(Q_MAX);
        if (v < Q_MIN)
            return DATA_W'(Q_MIN);
        return v[DATA_W-1:0];
    endfunction

    assign t_p0 = RQ_PROD_W'(acc_p0) * RQ_PROD_W'(mult);

    // ---- stage p0 -> p1 ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (vld_p0)
            t_p1 <= t_p0;
    end

    always_comb begin
        v_p1 = round_shift(t_p1, shift) + RQ_EXT_W'(zp_out);
        s_p1 = saturate(v_p1);
        q_p1 = s_p1;
        if (relu && (s_p1 < zp_out))
            q_p1 = zp_out;
    end

endmodule

// File: rtl/npu_fc_engine.sv
// int8 fully-connected engine: buffers the input vector, streams weights/bias per output,
// MACs LANES elements per read, requantizes and writes packed int8 results.
module npu_fc_engine
    import npu_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int LANES  = 4,
    parameter  int ACC_W  = 32,
    parameter  int ADDR_W = 32,
    parameter  int MAX_IN = 1024,
    parameter  int LEN_W  = 16,
    localparam int WORD_W = LANES * DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        cfg_in_ptr,
    input  logic [ADDR_W-1:0]        cfg_w_ptr,
    input  logic [ADDR_W-1:0]        cfg_b_ptr,
    input  logic [ADDR_W-1:0]        cfg_out_ptr,
    input  logic [LEN_W-1:0]         cfg_in_len,
    input  logic [LEN_W-1:0]         cfg_out_len,
    input  logic signed [8:0]        cfg_zp_in,
    input  logic signed [31:0]       cfg_mult,
    input  logic [5:0]               cfg_shift,
    input  logic signed [DATA_W-1:0] cfg_zp_out,
    input  logic                     cfg_relu,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [WORD_W-1:0]        mem_rdata
);

    localparam int LANE_B = $clog2(LANES);
    localparam int BUF_D  = MAX_IN / LANES;
    localparam int BUF_AW = $clog2(BUF_D);
    localparam int PROD_W = 2 * DATA_W + 2;
    localparam int SUM_W  = PROD_W + LANE_B;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(word_stride(LANES, DATA_W));

    npu_state_e              state;
    logic                    wait_rd;
    logic [LEN_W-1:0]        in_len_q, out_len_q, w_cnt, o_cnt;
    logic [ADDR_W-1:0]       in_ptr_q, w_addr, b_addr, o_addr;

    logic signed [8:0]        zp_in_q;
    logic signed [31:0]       mult_q;
    logic [5:0]               shift_q;
    logic signed [DATA_W-1:0] zp_out_q;
    logic                     relu_q;
    logic signed [ACC_W-1:0]  acc;
    logic [WORD_W-1:0]        out_word;
    logic [WORD_W-1:0]        in_buf [BUF_D];

    logic                     rd_done, last_word, last_out, need_wr, cfg_bad, store_adv;
    logic [LEN_W-1:0]         n_words;
    logic [WORD_W-1:0]        in_word, packed_word;
    logic signed [SUM_W-1:0]  dot;
    logic                     rq_vld_p1;
    logic signed [DATA_W-1:0] rq_q_p1;

    function automatic logic signed [PROD_W-1:0] lane_mac(
        input logic signed [DATA_W-1:0] x,
        input logic signed [8:0]        zp,
        input logic signed [DATA_W-1:0] wt
    );
        logic signed [DATA_W+1:0] xz;
        xz = (DATA_W+2)'(x) + (DATA_W+2)'(zp);
        return PROD_W'(xz) * PROD_W'(wt);
    endfunction

    assign rd_done   = wait_rd & mem_rvalid;
    assign n_words   = in_len_q >> LANE_B;
    assign last_word = (w_cnt == n_words - LEN_W'(1));
    assign last_out  = (o_cnt == out_len_q - LEN_W'(1));
    assign need_wr   = (&o_cnt[LANE_B-1:0]) || last_out;
    assign cfg_bad   = (in_len_q == '0) || (out_len_q == '0) ||
                       (in_len_q[LANE_B-1:0] != '0) || (in_len_q > LEN_W'(MAX_IN));
    assign store_adv = (state == ST_STORE) &&
                       ((rq_vld_p1 && !need_wr) || (!rq_vld_p1 && mem_req && mem_gnt));
    assign in_word   = in_buf[w_cnt[BUF_AW-1:0]];

    always_comb begin
        dot = '0;
        for (int l = 0; l < LANES; l++)
            dot = dot + SUM_W'(lane_mac($signed(in_word[l*DATA_W +: DATA_W]), zp_in_q,
                                        $signed(mem_rdata[l*DATA_W +: DATA_W])));
    end

    always_comb begin
        packed_word = out_word;
        for (int l = 0; l < LANES; l++)
            if (o_cnt[LANE_B-1:0] == LANE_B'(l))
                packed_word[l*DATA_W +: DATA_W] = rq_q_p1;
    end

    // ---- control: FSM and memory handshake ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_rd   <= 1'b0;
            in_len_q  <= '0;
            out_len_q <= '0;
            w_cnt     <= '0;
            o_cnt     <= '0;
            in_ptr_q  <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            o_addr    <= '0;
        end else begin
            if (mem_req && mem_gnt && !mem_we) begin
                mem_req <= 1'b0;
                wait_rd <= 1'b1;
            end
            if (rd_done)
                wait_rd <= 1'b0;

            case (state)
                ST_IDLE: if (start) begin
                    busy      <= 1'b1;
                    in_len_q  <= cfg_in_len;
                    out_len_q <= cfg_out_len;
                    in_ptr_q  <= cfg_in_ptr;
                    w_addr    <= cfg_w_ptr;
                    b_addr    <= cfg_b_ptr;
                    o_addr    <= cfg_out_ptr;
                    state     <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (cfg_bad) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= in_ptr_q;
                        w_cnt    <= '0;
                        o_cnt    <= '0;
                        state    <= ST_LOAD_IN;
                    end
                end
                ST_LOAD_IN: if (rd_done) begin
                    mem_req <= 1'b1;
                    if (last_word) begin
                        w_cnt    <= '0;
                        mem_addr <= b_addr;
                        state    <= ST_BIAS;
                    end else begin
                        w_cnt    <= w_cnt + LEN_W'(1);
                        mem_addr <= mem_addr + STRIDE;
                    end
                end
                ST_BIAS: if (rd_done) begin
                    mem_req  <= 1'b1;
                    mem_addr <= w_addr;
                    state    <= ST_MAC;
                end
                ST_MAC: if (rd_done) begin
                    w_addr <= w_addr + STRIDE;
                    if (last_word) begin
                        w_cnt <= '0;
                        state <= ST_REQ;
                    end else begin
                        w_cnt    <= w_cnt + LEN_W'(1);
                        mem_req  <= 1'b1;
                        mem_addr <= w_addr + STRIDE;
                    end
                end
                ST_REQ: state <= ST_STORE;
                ST_STORE: begin
                    if (rq_vld_p1 && need_wr) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= o_addr;
                        mem_wdata <= packed_word;
                    end
                    if (store_adv) begin
                        mem_we <= 1'b0;
                        o_cnt  <= o_cnt + LEN_W'(1);
                        b_addr <= b_addr + STRIDE;
                        if (mem_req)
                            o_addr <= o_addr + STRIDE;
                        if (last_out) begin
                            mem_req <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= b_addr + STRIDE;
                            state    <= ST_BIAS;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- datapath: config latch, input buffer, accumulator, output packing ----
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            zp_in_q  <= cfg_zp_in;
            mult_q   <= cfg_mult;
            shift_q  <= cfg_shift;
            zp_out_q <= cfg_zp_out;
            relu_q   <= cfg_relu;
        end
        if (state == ST_CHECK)
            out_word <= '0;
        if (state == ST_LOAD_IN && rd_done)
            in_buf[w_cnt[BUF_AW-1:0]] <= mem_rdata;
        if (state == ST_BIAS && rd_done)
            acc <= $signed(mem_rdata[ACC_W-1:0]);
        if (state == ST_MAC && rd_done)
            acc <= acc + ACC_W'(dot);
        if (state == ST_STORE && rq_vld_p1)
            out_word <= need_wr ? '0 : packed_word;
    end

    npu_requant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_requant (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_p0 (state == ST_REQ),
        .acc_p0 (acc),
        .mult   (mult_q),
        .shift  (shift_q),
        .zp_out (zp_out_q),
        .relu   (relu_q),
        .vld_p1 (rq_vld_p1),
        .q_p1   (rq_q_p1)
    );

endmodule

// File: tb/tb_npu_fc_engine.sv
// Directed bench for npu_fc_engine with a zero-wait (stallable) word memory model.
module tb_npu_fc_engine;

    localparam logic [31:0] IN_P = 32'h000;
    localparam logic [31:0] W_P  = 32'h100;
    localparam logic [31:0] B_P  = 32'h200;
    localparam logic [31:0] O_P  = 32'h300;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        cfg_in_ptr = IN_P, cfg_w_ptr = W_P, cfg_b_ptr = B_P, cfg_out_ptr = O_P;
    logic [15:0]        cfg_in_len = '0, cfg_out_len = '0;
    logic signed [8:0]  cfg_zp_in = '0;
    logic signed [31:0] cfg_mult = '0;
    logic [5:0]         cfg_shift = '0;
    logic signed [7:0]  cfg_zp_out = '0;
    logic               cfg_relu = 1'b0;
    logic               busy, done, err, mem_req, mem_we, mem_gnt;
    logic [31:0]        mem_addr, mem_wdata;
    logic               mem_rvalid = 1'b0;
    logic [31:0]        mem_rdata = '0;

    logic [31:0] mem [512];
    logic        gnt_en = 1'b1;
    int          wr_n = 0, req_n = 0;
    logic [31:0] wr_a [64];
    logic [31:0] wr_d [64];
    int          n_chk = 0, n_ok = 0;

    npu_fc_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_in_ptr(cfg_in_ptr), .cfg_w_ptr(cfg_w_ptr), .cfg_b_ptr(cfg_b_ptr), .cfg_out_ptr(cfg_out_ptr),
        .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len), .cfg_zp_in(cfg_zp_in),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp_out(cfg_zp_out), .cfg_relu(cfg_relu),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_gnt = mem_req & gnt_en;

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_req)
            req_n <= req_n + 1;
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                wr_a[wr_n[5:0]] <= mem_addr;
                wr_d[wr_n[5:0]] <= mem_wdata;
                wr_n <= wr_n + 1;
            end else begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem[mem_addr[10:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_ok++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] wd(input int idx);
        return (idx < wr_n) ? wr_d[idx[5:0]] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] wa(input int idx);
        return (idx < wr_n) ? wr_a[idx[5:0]] : 32'hDEADBEEF;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 512; i++)
            mem[i] = '0;
    endtask

    // Launches one job, scrambles cfg afterwards, waits (bounded) for done.
    task automatic run_fc(input logic [15:0] in_len, input logic [15:0] out_len,
                          input logic signed [8:0] zp_in, input logic signed [31:0] mult,
                          input logic [5:0] shift, input logic signed [7:0] zp_out,
                          input logic relu, output logic got_err, output int base);
        bit seen;
        @(negedge clk);
        cfg_in_len = in_len; cfg_out_len = out_len; cfg_zp_in = zp_in; cfg_mult = mult;
        cfg_shift = shift; cfg_zp_out = zp_out; cfg_relu = relu;
        base  = wr_n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_in_len = 16'd6; cfg_mult = 32'sd0; cfg_shift = 6'd63; cfg_relu = ~relu; cfg_zp_out = 8'sd50;
        seen = 1'b0;
        got_err = 1'b1;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (done) begin
                seen    = 1'b1;
                got_err = err;
            end else begin
                @(negedge clk);
            end
        end
        check("done_seen", seen, 1'b1);
        @(negedge clk);
    endtask

    logic        e;
    int          b, rc;
    bit          seen_de;
    logic [15:0] bad_in  [4] = '{16'd6, 16'd0, 16'd1028, 16'd4};
    logic [15:0] bad_out [4] = '{16'd1, 16'd1, 16'd1, 16'd0};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_req", mem_req, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_err", err, 1'b0);
        check("idle_req", mem_req, 1'b0);

        // basic dot product
        clear_mem();
        mem[0] = 32'h04030201; mem[64] = 32'h01010101; mem[128] = 32'd10;
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd0, 8'sd0, 1'b0, e, b);
        check("basic_err", e, 1'b0);
        check("basic_nwr", wr_n - b, 1);
        check("basic_addr", wa(b), O_P);
        check("basic_data", wd(b), 32'h00000014);
        check("basic_busy_after", busy, 1'b0);

        // saturation and relu
        mem[64] = 32'h0; mem[128] = 32'd1000;
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd0, 8'sd0, 1'b0, e, b);
        check("sat_hi", wd(b), 32'h0000007F);
        mem[128] = -32'sd1000;
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd0, 8'sd0, 1'b0, e, b);
        check("sat_lo", wd(b), 32'h00000080);
        mem[128] = -32'sd50;
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd0, 8'sd0, 1'b0, e, b);
        check("neg_norelu", wd(b), 32'h000000CE);
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd0, 8'sd0, 1'b1, e, b);
        check("neg_relu", wd(b), 32'h00000000);

        // rounding
        mem[128] = 32'd5;
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd1, 8'sd0, 1'b0, e, b);
        check("round_pos", wd(b), 32'h00000003);
        mem[128] = -32'sd5;
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd1, 8'sd0, 1'b0, e, b);
        check("round_neg", wd(b), 32'h000000FE);

        // input zero point cancels the inputs
        mem[0] = 32'h01010101; mem[64] = 32'h02020202; mem[128] = 32'd0;
        run_fc(16'd4, 16'd1, -9'sd1, 32'sd1, 6'd0, 8'sd0, 1'b0, e, b);
        check("zp_in", wd(b), 32'h00000000);

        // two input words, two outputs, output zero point -3
        clear_mem();
        mem[0] = 32'h04030201; mem[1] = 32'h08070605;
        mem[64] = 32'h01010101; mem[65] = 32'h01010101;
        mem[66] = 32'h02020202; mem[67] = 32'h02020202;
        mem[128] = 32'd1; mem[129] = -32'sd2;
        run_fc(16'd8, 16'd2, 9'sd0, 32'sd1, 6'd0, -8'sd3, 1'b0, e, b);
        check("two_nwr", wr_n - b, 1);
        check("two_data", wd(b), 32'h00004322);
        run_fc(16'd8, 16'd2, 9'sd0, 32'sd3, 6'd2, -8'sd3, 1'b0, e, b);
        check("two_mult_data", wd(b), 32'h00003219);

        // partial last word
        clear_mem();
        for (int i = 0; i < 5; i++)
            mem[128 + i] = i;
        run_fc(16'd4, 16'd5, 9'sd0, 32'sd1, 6'd0, 8'sd0, 1'b0, e, b);
        check("part_nwr", wr_n - b, 2);
        check("part_addr0", wa(b), O_P);
        check("part_data0", wd(b), 32'h03020100);
        check("part_addr1", wa(b + 1), O_P + 32'd4);
        check("part_data1", wd(b + 1), 32'h00000004);

        // bad configurations
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_in_len = bad_in[k]; cfg_out_len = bad_out[k];
            rc = req_n;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            seen_de = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (done && err)
                    seen_de = 1'b1;
                @(negedge clk);
            end
            check($sformatf("cfgerr%0d_done_err", k), seen_de, 1'b1);
            check($sformatf("cfgerr%0d_noreq", k), req_n - rc, 0);
            repeat (2) @(negedge clk);
        end

        // stall then reset mid LOAD_IN
        clear_mem();
        mem[0] = 32'h04030201; mem[64] = 32'h01010101; mem[128] = 32'd10;
        gnt_en = 1'b0;
        @(negedge clk);
        cfg_in_len = 16'd8; cfg_out_len = 16'd1; cfg_zp_in = '0; cfg_mult = 32'sd1;
        cfg_shift = '0; cfg_zp_out = '0; cfg_relu = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_req", i), mem_req, 1'b1);
            check($sformatf("stall%0d_addr", i), mem_addr, IN_P);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort_req", mem_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        gnt_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_fc(16'd4, 16'd1, 9'sd0, 32'sd1, 6'd0, 8'sd0, 1'b0, e, b);
        check("rerun_err", e, 1'b0);
        check("rerun_data", wd(b), 32'h00000014);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/npu_fc_engine.md
Name: npu_fc_engine

Overview:
- Parametrised int8 fully-connected engine for the TFLite softcore NPU; successor to the fixed-shape conv accelerator FSM.
- Loads the input vector into a local buffer, then streams weights and bias from external memory for each output.
- Per output it accumulates LANES MACs per cycle, requantizes to int8 (TFLite style) with optional ReLU, and writes packed results back.
- Sits beside the CPU on the shared memory port; the CPU supplies configuration and a start pulse.

Parameters:
DATA_W, 8, operand/output element width (signed)
LANES, 4, elements per memory word and MACs per cycle; WORD_W = LANES*DATA_W
ACC_W, 32, accumulator/bias width (signed)
ADDR_W, 32, byte address width
MAX_IN, 1024, input buffer depth in elements (multiple of LANES)
LEN_W, 16, width of length fields

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  launch; sampled only in IDLE
cfg_in_ptr / cfg_w_ptr / cfg_b_ptr / cfg_out_ptr  in  ADDR_W  word-aligned byte base addresses
cfg_in_len  in  LEN_W  input elements
cfg_out_len  in  LEN_W  output elements
cfg_zp_in  in  9  signed offset added to every input element
cfg_mult  in  32  signed requant multiplier
cfg_shift  in  6  arithmetic right shift, 0..63
cfg_zp_out  in  DATA_W  signed output zero point
cfg_relu  in  1  clamp low bound at cfg_zp_out
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end (success or error)
err  out  1  one-cycle pulse with done on bad config
mem_req  out  1  request valid
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  byte address
mem_wdata  out  WORD_W  write data, lane 0 in LSBs
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  WORD_W  read data, lane 0 in LSBs

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low. All outputs reset to 0. The FSM resets to IDLE.
- Reset mid-operation aborts immediately. mem_req drops asynchronously, and any in-flight read data is ignored after release.
- Configuration latch: in IDLE, start latches all cfg_* inputs. Later cfg changes have no effect. start while busy is ignored.
- Config validation (single cycle) fails if any of the following holds; on failure go to DONE with err=1 and issue no memory traffic:
  - in_len==0
  - out_len==0
  - in_len%LANES!=0
  - in_len>MAX_IN
- Memory handshake:
  - At most one outstanding request.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle mem_gnt=1. mem_req deasserts the cycle after grant unless a new request is issued.
  - A read completes on the first mem_rvalid after its grant. Writes complete at grant.
- States:
  - IDLE
  - CHECK
  - LOAD_IN: read in_len/LANES words from in_ptr+4*w into the buffer.
  - BIAS: read the word at b_ptr+4*o, i.e. WORD_W = ACC_W and one bias per word.
  - MAC: read in_len/LANES weight words at w_ptr+4*(o*in_len/LANES + w). On each rvalid, acc += sum over lanes of (in[l]+zp_in)*wt[l]. Products are 18b signed; the adder tree widens; the acc wraps at ACC_W.
  - REQ: requantize, one registered stage (t = 64b acc*mult, then one cycle to STORE).
  - STORE: pack the output into lane o%LANES of the out word. Write when lane LANES-1 is filled or o==out_len-1; unfilled lanes are 0. Address is out_ptr+4*(o/LANES).
  - DONE: pulse done; busy=0 on the following cycle; return to IDLE.
- Transitions: after STORE, o++. If o<out_len go to BIAS, else go to DONE.
- Requantization:
  - t = acc*cfg_mult (64b signed).
  - If shift>0, r = (t + 2^(shift-1)) >>> shift (round half up); else r = t.
  - v = r + zp_out.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If relu, v = max(v, zp_out).
- Minimum latency with 0-wait memory (gnt same cycle, rvalid next cycle): 2 cycles per read, 1 per write.

Decomposition:
- Shared package npu_pkg holds:
  - the FSM state enum
  - the requant rounding/saturation constants
  - a function for the lane address stride
- One natural sub-module: npu_requant (acc, mult, shift, zp, relu -> int8). Purely combinational plus one register stage, so it can be verified stand-alone.

Test Plan:
- Basic dot product, in_len=4, out_len=1:
  - stimulus: in=[1,2,3,4], wt=[1,1,1,1], bias=10, mult=1, shift=0, zp=0
  - response: one write at out_ptr with data 0x00000014; done pulse; err=0.
- Saturation and ReLU:
  - bias=1000, weights 0 -> lane0 = 0x7F.
  - bias=-50, relu=0 -> 0xCE; relu=1 -> 0x00.
- Rounding, mult=1, shift=1:
  - bias=5 -> 3.
  - bias=-5 -> -2 (0xFE).
  - zp_in=-1 with in=[1,1,1,1], wt=[2,2,2,2], bias=0 -> acc 0 -> 0x00.
- Partial word, out_len=5, bias 0..4, weights 0:
  - writes 0x03020100 at out_ptr, then 0x00000004 at out_ptr+4.
  - exactly 2 writes.
- Config error, in_len=6:
  - done and err pulse together within 3 cycles of start.
  - mem_req never asserted.
- Stall and reset:
  - hold mem_gnt=0 for 3 cycles -> mem_addr/mem_req stable.
  - assert rst_n=0 mid-LOAD_IN -> mem_req=0, busy=0 immediately.
  - a new start after release completes normally.
